// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target engine: default sizing and FSM states.
package spi_pkg;

   localparam int SPI_DWIDTH      = 8;
   localparam int SPI_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with registered
// rise/fall pulses that coincide with the transition of level_o.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   // Shift the pin through the chain and compare the last two samples for edges.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_i};
      prev_d = sync_q[STAGES-1];
      rise_d = sync_q[STAGES-1] & ~prev_q;
      fall_d = ~sync_q[STAGES-1] & prev_q;
   end

   // Synchronizer and edge-pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level_o = prev_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target serial engine, CPOL=0 / CPHA=1, MSB first. MISO changes on sclk
// rise, MOSI is captured on sclk fall; one DWIDTH word exchanged per word slot.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DWIDTH      = SPI_DWIDTH,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DWIDTH-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DWIDTH-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              busy
);

   localparam int                CNT_W    = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DWIDTH - 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ss_lvl, ss_rise, ss_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst     (rst),
      .async_i (sclk),
      .level_o (sclk_lvl),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   // Select resets deasserted so the engine never arms out of reset.
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk     (clk),
      .rst     (rst),
      .async_i (ss_n),
      .level_o (ss_lvl),
      .rise_o  (ss_rise),
      .fall_o  (ss_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk     (clk),
      .rst     (rst),
      .async_i (mosi),
      .level_o (mosi_lvl),
      .rise_o  (mosi_rise),
      .fall_o  (mosi_fall)
   );

   // Only sclk edges and the ss_n/mosi levels drive the engine.
   assign unused_sync = ^{sclk_lvl, ss_rise, ss_fall, mosi_rise, mosi_fall};

   spi_state_e               state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [DWIDTH-1:0]        tx_sr_q, tx_sr_d;
   logic [DWIDTH-2:0]        rx_sr_q, rx_sr_d;
   logic [DWIDTH-1:0]        rx_data_q, rx_data_d;
   logic                     rx_valid_q, rx_valid_d;
   logic                     tx_underrun_q, tx_underrun_d;
   logic                     miso_q, miso_d;
   logic                     busy_q, busy_d;
   logic [DWIDTH-1:0]        hold_q, hold_d;
   logic                     hold_full_q, hold_full_d;
   logic                     consume;
   logic [DWIDTH-1:0]        rx_word;

   assign rx_word = {rx_sr_q, mosi_lvl};

   // Next-state logic: select handling, word framing, shifting and holding buffer.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tx_sr_d       = tx_sr_q;
      rx_sr_d       = rx_sr_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_underrun_d = 1'b0;
      miso_d        = miso_q;
      busy_d        = ~ss_lvl;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      consume       = 1'b0;

      if (ss_lvl) begin
         // Deselect wins over any sclk edge; a partial word is dropped.
         state_d = IDLE;
         cnt_d   = '0;
         tx_sr_d = '0;
         rx_sr_d = '0;
         miso_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = ARMED;
            end
            ARMED: begin
               if (sclk_rise) begin
                  consume = 1'b1;
                  state_d = SHIFT;
                  if (hold_full_q) begin
                     {miso_d, tx_sr_d} = {hold_q, 1'b0};
                  end else begin
                     miso_d        = 1'b0;
                     tx_sr_d       = '0;
                     tx_underrun_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  {miso_d, tx_sr_d} = {tx_sr_q, 1'b0};
               end else if (sclk_fall) begin
                  rx_sr_d = rx_word[DWIDTH-2:0];
                  cnt_d   = cnt_q + 1'b1;
                  if (cnt_q == LAST_BIT) begin
                     rx_data_d  = rx_word;
                     rx_valid_d = 1'b1;
                     cnt_d      = '0;
                     state_d    = ARMED;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // Word start empties the buffer first, so a same-cycle load is kept for the next word.
      if (consume) begin
         hold_full_d = 1'b0;
      end
      if (tx_valid && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_d      = tx_data;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tx_sr_q       <= '0;
         rx_sr_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         miso_q        <= 1'b0;
         busy_q        <= 1'b0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tx_sr_q       <= tx_sr_d;
         rx_sr_q       <= rx_sr_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_underrun_q <= tx_underrun_d;
         miso_q        <= miso_d;
         busy_q        <= busy_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
      end
   end

   assign miso        = miso_q & busy_q;
   assign miso_oe     = busy_q;
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = tx_underrun_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a CPOL=0/CPHA=1 master at clk/8 plus a transaction-level
// model of the holding buffer and receive stream.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk, ss_n, mosi;
   logic       miso, miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, tx_underrun, busy;

   always #5 clk = ~clk;

   spi_slave #(.DWIDTH(8), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .ss_n        (ss_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underrun (tx_underrun),
      .busy        (busy)
   );

   int         vectors     = 0;
   int         miscompares = 0;
   int         rx_pulses   = 0;
   int         under_pulses = 0;
   int         exp_under   = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] hold_m[$];
   logic       rx_valid_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Continuous comparison of the receive stream, pulse shape and pad enable.
   always @(negedge clk) begin
      check("miso_oe_eq_busy", miso_oe, busy);
      if (!miso_oe) check("miso_quiet", miso, 1'b0);
      if (rx_valid) begin
         rx_pulses++;
         check("rx_valid_width", {rx_valid_prev, rx_valid}, 2'b01);
         check("rx_expected", exp_rx.size() != 0, 1'b1);
         if (exp_rx.size() != 0) check("rx_data_stream", rx_data, exp_rx.pop_front());
      end
      if (tx_underrun) under_pulses++;
      rx_valid_prev = rx_valid;
   end

   task automatic load(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      hold_m.push_back(d);
      check("tx_ready_after_load", tx_ready, 1'b0);
   endtask

   task automatic frame_begin();
      ss_n = 1'b0;
      repeat (8) @(negedge clk);
      check("busy_in_frame", busy, 1'b1);
      check("miso_oe_in_frame", miso_oe, 1'b1);
   endtask

   task automatic frame_end();
      repeat (6) @(negedge clk);
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
      check("busy_after_frame", busy, 1'b0);
      check("miso_oe_after_frame", miso_oe, 1'b0);
      check("underrun_count", under_pulses, exp_under);
   endtask

   // Master side of one word slot: drive mosi on rise, capture miso just before fall.
   task automatic do_word(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      logic [7:0] exp_word;
      if (hold_m.size() != 0) begin
         exp_word = hold_m.pop_front();
      end else begin
         exp_word = 8'h00;
         exp_under++;
      end
      if (nbits == 8) exp_rx.push_back(mo);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         mosi = mo[7-i];
         repeat (4) @(negedge clk);
         mi[7-i] = miso;
         sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
      check("miso_bits", mi >> (8 - nbits), exp_word >> (8 - nbits));
   endtask

   logic [7:0] m, m1, m2;

   initial begin
      rst = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_miso", miso, 1'b0);
      check("rst_miso_oe", miso_oe, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_tx_underrun", tx_underrun, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // T1: single word, tx 0xA5 against rx 0x3C
      load(8'hA5);
      frame_begin();
      do_word(8'h3C, 8, m);
      frame_end();
      check("t1_miso_word", m, 8'hA5);
      check("t1_rx_data", rx_data, 8'h3C);
      check("t1_rx_count", rx_pulses, 1);

      // T2: back-to-back words, second tx word loaded during the first
      load(8'h81);
      frame_begin();
      fork
         begin
            do_word(8'h5A, 8, m1);
            do_word(8'hC6, 8, m2);
         end
         begin
            repeat (24) @(negedge clk);
            load(8'h7E);
         end
      join
      frame_end();
      check("t2_miso_word1", m1, 8'h81);
      check("t2_miso_word2", m2, 8'h7E);
      check("t2_rx_data", rx_data, 8'hC6);
      check("t2_rx_count", rx_pulses, 3);

      // T3: empty buffer at word start
      frame_begin();
      do_word(8'hFF, 8, m);
      frame_end();
      check("t3_miso_word", m, 8'h00);
      check("t3_underruns", under_pulses, 1);
      check("t3_rx_data", rx_data, 8'hFF);

      // T4: abort after 4 bits, buffer loaded mid-word survives to next frame
      frame_begin();
      do_word(8'hF0, 4, m);
      load(8'h96);
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
      check("t4_no_rx_valid", rx_pulses, 4);
      check("t4_rx_data_kept", rx_data, 8'hFF);
      check("t4_underruns", under_pulses, 2);
      check("t4_busy_low", busy, 1'b0);
      frame_begin();
      do_word(8'h55, 8, m);
      frame_end();
      check("t4_miso_retained", m, 8'h96);
      check("t4_rx_data_clean", rx_data, 8'h55);
      check("t4_rx_count", rx_pulses, 5);

      // T5: asynchronous reset in the middle of a word
      load(8'hC3);
      frame_begin();
      do_word(8'hAA, 3, m);
      rst = 1'b0;
      #1;
      check("t5_miso", miso, 1'b0);
      check("t5_miso_oe", miso_oe, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_tx_ready", tx_ready, 1'b1);
      check("t5_rx_data", rx_data, 8'h00);
      check("t5_rx_valid", rx_valid, 1'b0);
      check("t5_tx_underrun", tx_underrun, 1'b0);
      hold_m.delete();
      ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // T6: tx_valid held against a full buffer
      load(8'h11);
      tx_data  = 8'h22;
      tx_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_ready_blocked", tx_ready, 1'b0);
      frame_begin();
      fork
         begin
            do_word(8'h0F, 8, m1);
            do_word(8'hE1, 8, m2);
         end
         begin
            int n;
            n = 0;
            while (!tx_ready && n < 60) begin
               @(negedge clk);
               n++;
            end
            check("t6_ready_frees", tx_ready, 1'b1);
            @(negedge clk);
            tx_valid = 1'b0;
            hold_m.push_back(8'h22);
         end
      join
      frame_end();
      check("t6_miso_word1", m1, 8'h11);
      check("t6_miso_word2", m2, 8'h22);
      check("t6_rx_data", rx_data, 8'hE1);
      check("t6_rx_count", rx_pulses, 7);

      check("rx_queue_drained", exp_rx.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
